// File: rtl/serial_adder_ctrl_pkg.sv
// rtl/serial_adder_ctrl_pkg.sv - shared state encodings and types for the serial adder controller
`ifndef SERIAL_ADDER_CTRL_STATES
`define SERIAL_ADDER_CTRL_STATES
`define ST_IDLE 2'd0
`define ST_RUN  2'd1
`define ST_DONE 2'd2
`endif

package serial_adder_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = `ST_IDLE,
    S_RUN  = `ST_RUN,
    S_DONE = `ST_DONE
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - operand/result handshake bundle for the serial adder
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, carry_out, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, carry_out, busy
  );

endinterface

// File: rtl/Half_Adder.sv
// rtl/Half_Adder.sv - one-bit half adder
module Half_Adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  // sum and carry of two bits
  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_fa_slice.sv
// rtl/serial_fa_slice.sv - structural 1-bit full adder from two half adders and an OR
module serial_fa_slice (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;
  logic g0;
  logic g1;

  Half_Adder u_ha0 (
    .a (x),
    .b (y),
    .s (p),
    .c (g0)
  );

  Half_Adder u_ha1 (
    .a (p),
    .b (cin),
    .s (s),
    .c (g1)
  );

  or u_or (cout, g0, g1);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder: FSM, shift registers, counter and handshakes
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                clk,
  input logic                rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_reg;
  logic [CNT_W-1:0] count;

  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  logic             s;
  logic             c;
  logic [WIDTH-1:0] sum_next;

  serial_fa_slice u_slice (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (carry_reg),
    .s    (s),
    .cout (c)
  );

  // new slice result enters at the MSB while the partial sum drifts toward the LSB
  assign sum_next = (sum_sh >> 1) | (WIDTH'(s) << (WIDTH - 1));

  // controller FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      carry_reg   <= 1'b0;
      count       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.a;
            b_sh       <= bus.b;
            carry_reg  <= 1'b0;
            count      <= '0;
            state      <= S_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          sum_sh    <= sum_next;
          carry_reg <= c;
          count     <= count + 1'b1;
          if (count == LAST) begin
            // final slice lands in the result registers on the same edge
            state       <= S_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            sum_q       <= sum_next;
            carry_q     <= c;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_q;

endmodule
